// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default framing
// constants used by both the transmitter and the oversampled receiver.
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..OVERSAMPLE-1 while enabled and wraps, flagging
// the last cycle of each bit period. Synchronous clear holds it at zero.
// Shared between the transmitter and the receiver.
module uart_bit_timer
#(
    parameter int OVERSAMPLE = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bit_done
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CW-1:0] cnt;

    assign bit_done = (cnt == CW'(OVERSAMPLE - 1));

    // Free-running bit counter, restarted on every wrap or clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and registered tx line.
// Optional parity bit is compiled in by defining UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DATA_BITS  = UART_DATA_BITS_DEF,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Reject configurations the framing logic cannot represent.
    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("uart_tx: OVERSAMPLE must be at least 2");
    end
    if (DATA_BITS < 2) begin : g_bad_db
        $error("uart_tx: DATA_BITS must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 tx_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign shreg_next = shreg >> 1;

    // ready_r already sits at 1 in the cycle after reset releases; masking
    // with reset keeps ready low for as long as reset is held.
    assign ready = ready_r & ~reset;
    assign tx    = tx_r;
    assign busy  = busy_r;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (state != TX_IDLE),
        .clr      (state == TX_IDLE),
        .bit_done (bit_done)
    );

    // Frame sequencer: accepts a byte in IDLE, then drives start, data,
    // optional parity and stop bits, each held for one bit-timer period.
    // tx is loaded one edge ahead so the line changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx_r     <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    if (valid && ready_r) begin
                        shreg    <= data;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tx_r     <= 1'b0;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= TX_START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                TX_START: begin
                    if (bit_done) begin
                        tx_r  <= shreg[0];
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_r  <= parity_bit;
                            state <= TX_PARITY;
`else
                            tx_r  <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            shreg   <= shreg_next;
                            bit_idx <= bit_idx + 1'b1;
                            tx_r    <= shreg_next[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_done) begin
                        tx_r  <= 1'b1;
                        state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_done) begin
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state   <= TX_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: waveform-exact frame checks against a cycle
// model, back-to-back handshake spacing, ignored valid during busy, mid-frame
// reset, parity (when UART_TX_PARITY_EN is defined) and a 256-byte loopback
// through a mid-bit-sampling receiver model.
module tb_uart_tx;

    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam int POD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = OS * (1 + DB + P + SB);

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          ready;
    logic          tx;
    logic          busy;

    always #5 clk = ~clk;

    uart_tx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB),
        .PARITY_ODD (POD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DB-1:0] send_q[$];
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] rx_q[$];
    logic          tr_tx[$];
    logic          tr_rdy[$];
    logic          tr_busy[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Producer plus recorder: presents send_q bytes with valid, pops a byte on
    // each handshake, optionally forces valid with 0xFF over cycles g_lo..g_hi,
    // and records tx/ready/busy for cycles 1..n after the first edge.
    task automatic capture(input string tag, input int n, input int g_lo, input int g_hi);
        logic prod;
        logic acc;
        tr_tx.delete();
        tr_rdy.delete();
        tr_busy.delete();
        check({tag, " ready before send"}, ready, 1'b1);
        prod = (send_q.size() > 0);
        if (prod) begin
            valid = 1'b1;
            data  = send_q[0];
        end
        for (int k = 1; k <= n; k++) begin
            acc = prod && valid && ready;
            tick();
            if (acc && send_q.size() > 0) void'(send_q.pop_front());
            if (send_q.size() > 0) begin
                valid = 1'b1;
                data  = send_q[0];
                prod  = 1'b1;
            end else begin
                valid = 1'b0;
                data  = DB'($urandom);
                prod  = 1'b0;
            end
            if (k >= g_lo && k <= g_hi) begin
                valid = 1'b1;
                data  = '1;
                prod  = 1'b0;
            end
            tr_tx.push_back(tx);
            tr_rdy.push_back(ready);
            tr_busy.push_back(busy);
        end
        valid = 1'b0;
    endtask

    // Cycle model: frame i is accepted on edge i*(F+1) and occupies recorded
    // cycles i*(F+1)+1 .. i*(F+1)+F; the cycle after each frame is idle.
    task automatic model(input int k, output logic etx, output logic erdy, output logic ebusy);
        int            i;
        int            j;
        logic [DB-1:0] d;
        i = (k - 1) / (F + 1);
        j = k - i * (F + 1);
        etx   = 1'b1;
        erdy  = 1'b1;
        ebusy = 1'b0;
        if (i < exp_q.size() && j <= F) begin
            d     = exp_q[i];
            erdy  = 1'b0;
            ebusy = 1'b1;
            if (j <= OS)
                etx = 1'b0;
            else if (j <= OS * (1 + DB))
                etx = d[(j - OS - 1) / OS];
            else if (P == 1 && j <= OS * (2 + DB))
                etx = (^d) ^ (POD != 0);
            else
                etx = 1'b1;
        end
    endtask

    task automatic compare_trace(input string tag);
        logic etx;
        logic erdy;
        logic ebusy;
        int   m_tx;
        int   m_rdy;
        int   m_busy;
        int   first;
        m_tx   = 0;
        m_rdy  = 0;
        m_busy = 0;
        first  = -1;
        for (int idx = 0; idx < tr_tx.size(); idx++) begin
            model(idx + 1, etx, erdy, ebusy);
            if (tr_tx[idx] !== etx) m_tx++;
            if (tr_rdy[idx] !== erdy) m_rdy++;
            if (tr_busy[idx] !== ebusy) m_busy++;
            if (first < 0 && (tr_tx[idx] !== etx || tr_rdy[idx] !== erdy || tr_busy[idx] !== ebusy))
                first = idx + 1;
        end
        if (first >= 0) $display("note %s: first divergent cycle %0d", tag, first);
        check({tag, " tx mismatching cycles"}, m_tx, 0);
        check({tag, " ready mismatching cycles"}, m_rdy, 0);
        check({tag, " busy mismatching cycles"}, m_busy, 0);
    endtask

    // Receiver model: find a falling edge, sample every bit at its centre,
    // verify start low, parity (if built in) and stop high.
    task automatic decode_and_check(input string tag);
        int            i;
        int            ferr;
        int            perr;
        logic [DB-1:0] b;
        rx_q.delete();
        ferr = 0;
        perr = 0;
        i = 0;
        while (i < tr_tx.size()) begin
            if (tr_tx[i] == 1'b0) begin
                if (i + OS * (1 + DB + P + SB) > tr_tx.size()) break;
                if (tr_tx[i + OS/2 - 1] != 1'b0) ferr++;
                for (int bt = 0; bt < DB; bt++)
                    b[bt] = tr_tx[i + OS * (bt + 1) + OS/2 - 1];
                if (P == 1 && tr_tx[i + OS * (DB + 1) + OS/2 - 1] != ((^b) ^ (POD != 0))) perr++;
                if (tr_tx[i + OS * (DB + 1 + P) + OS/2 - 1] != 1'b1) ferr++;
                rx_q.push_back(b);
                i = i + OS * (DB + 1 + P) + OS/2;
            end else begin
                i++;
            end
        end
        check({tag, " frames decoded"}, rx_q.size(), exp_q.size());
        check({tag, " framing errors"}, ferr, 0);
        check({tag, " parity errors"}, perr, 0);
        for (int q = 0; q < rx_q.size() && q < exp_q.size(); q++)
            check($sformatf("%s byte %0d", tag, q), rx_q[q], exp_q[q]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("reset tx", tx, 1'b1);
        check("reset ready", ready, 1'b0);
        check("reset busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check("post-reset ready", ready, 1'b1);
        check("post-reset tx", tx, 1'b1);

        // Single 0x55 frame, exact waveform, ready low F cycles
        send_q = '{8'h55};
        exp_q  = '{8'h55};
        capture("t1 0x55", F + 1, 0, -1);
        compare_trace("t1 0x55");
        decode_and_check("t1 0x55");

        // Back-to-back with valid held: second accept F+1 cycles after the first
        send_q = '{8'hA3, 8'h0F};
        exp_q  = '{8'hA3, 8'h0F};
        capture("t2 b2b", 2 * (F + 1) + 4, 0, -1);
        compare_trace("t2 b2b");
        decode_and_check("t2 b2b");

        // valid pulsed with 0xFF while busy must be ignored
        send_q = '{8'h81};
        exp_q  = '{8'h81};
        capture("t3 ignore", F + 1 + 40, 40, 43);
        compare_trace("t3 ignore");
        decode_and_check("t3 ignore");

        // Reset at cycle 70 of a frame (inside a 0 data bit)
        send_q = '{8'h00};
        exp_q  = '{8'h00};
        capture("t4 partial", 70, 0, -1);
        compare_trace("t4 partial");
        check("t4 tx low before reset", tx, 1'b0);
        reset = 1'b1;
        tick();
        check("t4 tx after reset edge", tx, 1'b1);
        check("t4 ready during reset", ready, 1'b0);
        check("t4 busy during reset", busy, 1'b0);
        reset = 1'b0;
        tick();
        check("t4 ready after reset", ready, 1'b1);
        check("t4 tx idle after reset", tx, 1'b1);
        send_q = '{8'h3C};
        exp_q  = '{8'h3C};
        capture("t4 0x3C", F + 1, 0, -1);
        compare_trace("t4 0x3C");
        decode_and_check("t4 0x3C");

        // 0x07: odd popcount, parity bit 1 for even parity when compiled in
        send_q = '{8'h07};
        exp_q  = '{8'h07};
        capture("t5 0x07", F + 1, 0, -1);
        compare_trace("t5 0x07");
        decode_and_check("t5 0x07");

        // Random 256-byte sweep through the receiver model
        send_q.delete();
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            logic [DB-1:0] r;
            r = DB'($urandom_range(0, 255));
            send_q.push_back(r);
            exp_q.push_back(r);
        end
        capture("t6 sweep", 256 * (F + 1), 0, -1);
        compare_trace("t6 sweep");
        decode_and_check("t6 sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
